// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline hazard controller.
package pipe_pkg;

   localparam int unsigned FWD_W  = 2;
   localparam int unsigned SCNT_W = 2;

   // Operand source select driven onto a_depen / b_depen
   typedef enum logic [FWD_W-1:0] {
      FWD_RF    = 2'd0,
      FWD_EXA   = 2'd1,
      FWD_MEMA  = 2'd2,
      FWD_MEMLD = 2'd3
   } fwd_sel_e;

   // Load-use stall FSM states
   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_LDSTALL = 1'b1
   } hz_state_e;

endpackage

// File: rtl/pipe_fwd_sel.sv
// Per-operand forwarding decode and load-use detection for one ID source.
module pipe_fwd_sel
   import pipe_pkg::*;
#(
   parameter int unsigned RW = 5
) (
   input  logic [RW-1:0] src,
   input  logic          use_src,
   input  logic [RW-1:0] ern,
   input  logic          ewreg,
   input  logic          em2reg,
   input  logic [RW-1:0] mrn,
   input  logic          mwreg,
   input  logic          mm2reg,
   output fwd_sel_e      depen_c,
   output logic          luh_c
);

   logic live;
   logic ex_hit;
   logic mem_hit;

   // A source only participates when it is read and is not the zero register
   assign live    = use_src && (src != '0);
   assign ex_hit  = live && (src == ern) && ewreg;
   assign mem_hit = live && (src == mrn) && mwreg;

   // EX ALU results win over anything in MEM; an EX load cannot be forwarded
   always_comb begin
      depen_c = FWD_RF;
      if (ex_hit && !em2reg) begin
         depen_c = FWD_EXA;
      end else if (mem_hit) begin
         depen_c = mm2reg ? FWD_MEMLD : FWD_MEMA;
      end
   end

   assign luh_c = ex_hit && em2reg;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard control: forwarding selects, load-use stall FSM,
// IF flush on redirect and a saturating stall counter.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int unsigned NREG     = 32,
   parameter int unsigned RW       = $clog2(NREG),
   parameter int unsigned LOAD_LAT = 1,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic [RW-1:0]    rs,
   input  logic [RW-1:0]    rt,
   input  logic             use_rs,
   input  logic             use_rt,
   input  logic [RW-1:0]    ern,
   input  logic             ewreg,
   input  logic             em2reg,
   input  logic [RW-1:0]    mrn,
   input  logic             mwreg,
   input  logic             mm2reg,
   input  logic [1:0]       pcsource,
   output logic             stall,
   output logic             bubble,
   output logic             flush_if,
   output logic [1:0]       a_depen,
   output logic [1:0]       b_depen,
   output logic [CNT_W-1:0] stall_cnt
);

   // Remaining LDSTALL cycles after the first stall cycle spent in IDLE
   localparam logic [SCNT_W-1:0] SCNT_INIT =
      (LOAD_LAT > 1) ? SCNT_W'(LOAD_LAT - 2) : '0;

   hz_state_e         state, state_nxt;
   logic [SCNT_W-1:0] scnt, scnt_nxt;
   fwd_sel_e          a_sel, b_sel;
   logic              luh_a, luh_b, luh;

   pipe_fwd_sel #(.RW(RW)) u_fwd_a (
      .src     (rs),
      .use_src (use_rs),
      .ern     (ern),
      .ewreg   (ewreg),
      .em2reg  (em2reg),
      .mrn     (mrn),
      .mwreg   (mwreg),
      .mm2reg  (mm2reg),
      .depen_c (a_sel),
      .luh_c   (luh_a)
   );

   pipe_fwd_sel #(.RW(RW)) u_fwd_b (
      .src     (rt),
      .use_src (use_rt),
      .ern     (ern),
      .ewreg   (ewreg),
      .em2reg  (em2reg),
      .mrn     (mrn),
      .mwreg   (mwreg),
      .mm2reg  (mm2reg),
      .depen_c (b_sel),
      .luh_c   (luh_b)
   );

   assign luh     = luh_a || luh_b;
   assign a_depen = a_sel;
   assign b_depen = b_sel;

   // State, down-counter and saturating stall counter
   always_ff @(posedge clk) begin
      if (clrn) begin
         state     <= ST_IDLE;
         scnt      <= '0;
         stall_cnt <= '0;
      end else begin
         state <= state_nxt;
         scnt  <= scnt_nxt;
         if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
      end
   end

   // Next state and stall/bubble; reset masks every control output
   always_comb begin
      state_nxt = state;
      scnt_nxt  = scnt;
      stall     = 1'b0;
      bubble    = 1'b0;
      if (!clrn) begin
         case (state)
            ST_IDLE: begin
               if (luh) begin
                  stall  = 1'b1;
                  bubble = 1'b1;
                  if (LOAD_LAT > 1) begin
                     state_nxt = ST_LDSTALL;
                     scnt_nxt  = SCNT_INIT;
                  end
               end
            end
            ST_LDSTALL: begin
               stall  = 1'b1;
               bubble = 1'b1;
               if (scnt == '0) begin
                  state_nxt = ST_IDLE;
               end else begin
                  scnt_nxt = scnt - SCNT_W'(1);
               end
            end
            default: begin
               state_nxt = ST_IDLE;
               scnt_nxt  = '0;
            end
         endcase
      end
   end

   // A redirect is held off while stalled and taken once the stall clears
   assign flush_if = (pcsource != 2'd0) && !stall && !clrn;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: combinational vector table plus multi-cycle stall sequences
// on three configurations (LOAD_LAT 1, 3, and 4 with a 2-bit counter).
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       clrn;
   logic [4:0] rs, rt, ern, mrn;
   logic       use_rs, use_rt, ewreg, em2reg, mwreg, mm2reg;
   logic [1:0] pcsource;

   logic        s1, b1, f1;
   logic [1:0]  a1, bd1;
   logic [31:0] c1;
   logic        s3, b3, f3;
   logic [1:0]  a3, bd3;
   logic [31:0] c3;
   logic        s4, b4, f4;
   logic [1:0]  a4, bd4;
   logic [1:0]  c4;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.NREG(32), .LOAD_LAT(1), .CNT_W(32)) u_lat1 (
      .clk(clk), .clrn(clrn), .rs(rs), .rt(rt), .use_rs(use_rs), .use_rt(use_rt),
      .ern(ern), .ewreg(ewreg), .em2reg(em2reg), .mrn(mrn), .mwreg(mwreg),
      .mm2reg(mm2reg), .pcsource(pcsource), .stall(s1), .bubble(b1),
      .flush_if(f1), .a_depen(a1), .b_depen(bd1), .stall_cnt(c1));

   pipe_hazard_ctrl #(.NREG(32), .LOAD_LAT(3), .CNT_W(32)) u_lat3 (
      .clk(clk), .clrn(clrn), .rs(rs), .rt(rt), .use_rs(use_rs), .use_rt(use_rt),
      .ern(ern), .ewreg(ewreg), .em2reg(em2reg), .mrn(mrn), .mwreg(mwreg),
      .mm2reg(mm2reg), .pcsource(pcsource), .stall(s3), .bubble(b3),
      .flush_if(f3), .a_depen(a3), .b_depen(bd3), .stall_cnt(c3));

   pipe_hazard_ctrl #(.NREG(32), .LOAD_LAT(4), .CNT_W(2)) u_lat4 (
      .clk(clk), .clrn(clrn), .rs(rs), .rt(rt), .use_rs(use_rs), .use_rt(use_rt),
      .ern(ern), .ewreg(ewreg), .em2reg(em2reg), .mrn(mrn), .mwreg(mwreg),
      .mm2reg(mm2reg), .pcsource(pcsource), .stall(s4), .bubble(b4),
      .flush_if(f4), .a_depen(a4), .b_depen(bd4), .stall_cnt(c4));

   typedef struct {
      string      name;
      logic [4:0] rs, rt;
      logic       use_rs, use_rt;
      logic [4:0] ern;
      logic       ewreg, em2reg;
      logic [4:0] mrn;
      logic       mwreg, mm2reg;
      logic [1:0] pcs;
      logic       e_stall, e_flush;
      logic [1:0] e_a, e_b;
   } vec_t;

   vec_t vecs[12];

   function automatic vec_t mk(input string nm,
                               input logic [4:0] vrs, input logic [4:0] vrt,
                               input logic urs, input logic urt,
                               input logic [4:0] vern, input logic vew, input logic vem,
                               input logic [4:0] vmrn, input logic vmw, input logic vmm,
                               input logic [1:0] vpcs,
                               input logic es, input logic ef,
                               input logic [1:0] ea, input logic [1:0] eb);
      vec_t v;
      v.name = nm; v.rs = vrs; v.rt = vrt; v.use_rs = urs; v.use_rt = urt;
      v.ern = vern; v.ewreg = vew; v.em2reg = vem;
      v.mrn = vmrn; v.mwreg = vmw; v.mm2reg = vmm; v.pcs = vpcs;
      v.e_stall = es; v.e_flush = ef; v.e_a = ea; v.e_b = eb;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic idle_in();
      rs = 5'd0; rt = 5'd0; use_rs = 1'b0; use_rt = 1'b0;
      ern = 5'd0; ewreg = 1'b0; em2reg = 1'b0;
      mrn = 5'd0; mwreg = 1'b0; mm2reg = 1'b0;
      pcsource = 2'd0;
   endtask

   task automatic luh_in();
      rs = 5'd4; use_rs = 1'b1; ern = 5'd4; ewreg = 1'b1; em2reg = 1'b1;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clrn = 1'b1;
      idle_in();
      next_cycle();
      clrn = 1'b0;
   endtask

   initial begin
      //                 name        rs  rt  urs  urt  ern ew em  mrn mw mm pcs  stall flush a  b
      vecs[0]  = mk("ex_fwd",     5,  0,  1,   0,   5,  1, 0,  0, 0, 0, 0,   0,    0,    1, 0);
      vecs[1]  = mk("ex_prio",    5,  0,  1,   0,   5,  1, 0,  5, 1, 0, 0,   0,    0,    1, 0);
      vecs[2]  = mk("r0_no_fwd",  0,  0,  0,   1,   0,  1, 0,  0, 0, 0, 0,   0,    0,    0, 0);
      vecs[3]  = mk("mem_load",   0,  7,  0,   1,   0,  0, 0,  7, 1, 1, 0,   0,    0,    0, 3);
      vecs[4]  = mk("mem_alu",    3,  0,  1,   0,   0,  0, 0,  3, 1, 0, 0,   0,    0,    2, 0);
      vecs[5]  = mk("unused_rs",  3,  0,  0,   0,   0,  0, 0,  3, 1, 0, 0,   0,    0,    0, 0);
      vecs[6]  = mk("luh_rs",     4,  0,  1,   0,   4,  1, 1,  0, 0, 0, 0,   1,    0,    0, 0);
      vecs[7]  = mk("luh_unused", 4,  4,  0,   0,   4,  1, 1,  0, 0, 0, 0,   0,    0,    0, 0);
      vecs[8]  = mk("redirect",   0,  0,  0,   0,   0,  0, 0,  0, 0, 0, 2,   0,    1,    0, 0);
      vecs[9]  = mk("redir_stl",  0,  4,  0,   1,   4,  1, 1,  0, 0, 0, 1,   1,    0,    0, 0);
      vecs[10] = mk("no_wreg",    5,  0,  1,   0,   5,  0, 0,  5, 0, 1, 0,   0,    0,    0, 0);
      vecs[11] = mk("both_ex",    9,  9,  1,   1,   9,  1, 0,  0, 0, 0, 0,   0,    0,    1, 1);

      // Reset cycle masks control outputs even with a live hazard and redirect
      idle_in();
      clrn = 1'b1;
      luh_in();
      pcsource = 2'd2;
      @(negedge clk);
      chk("rst_stall1", 32'(s1), 32'd0);
      chk("rst_stall4", 32'(s4), 32'd0);
      chk("rst_bubble3", 32'(b3), 32'd0);
      chk("rst_flush3", 32'(f3), 32'd0);
      next_cycle();
      clrn = 1'b0;
      idle_in();
      @(negedge clk);
      chk("rst_cnt1", c1, 32'd0);
      chk("rst_cnt4", 32'(c4), 32'd0);
      chk("rst_stall3", 32'(s3), 32'd0);
      next_cycle();

      // Combinational vectors checked on the LOAD_LAT=1 instance (always IDLE)
      for (int i = 0; i < 12; i++) begin
         rs = vecs[i].rs; rt = vecs[i].rt;
         use_rs = vecs[i].use_rs; use_rt = vecs[i].use_rt;
         ern = vecs[i].ern; ewreg = vecs[i].ewreg; em2reg = vecs[i].em2reg;
         mrn = vecs[i].mrn; mwreg = vecs[i].mwreg; mm2reg = vecs[i].mm2reg;
         pcsource = vecs[i].pcs;
         @(negedge clk);
         chk({vecs[i].name, ".stall"},  32'(s1),  32'(vecs[i].e_stall));
         chk({vecs[i].name, ".bubble"}, 32'(b1),  32'(vecs[i].e_stall));
         chk({vecs[i].name, ".flush"},  32'(f1),  32'(vecs[i].e_flush));
         chk({vecs[i].name, ".a"},      32'(a1),  32'(vecs[i].e_a));
         chk({vecs[i].name, ".b"},      32'(bd1), 32'(vecs[i].e_b));
         next_cycle();
      end

      // One-cycle load-use with a pending redirect
      do_reset();
      luh_in();
      pcsource = 2'd2;
      @(negedge clk);
      chk("seq1_c0_s3", 32'(s3), 32'd1);
      chk("seq1_c0_b3", 32'(b3), 32'd1);
      chk("seq1_c0_f3", 32'(f3), 32'd0);
      chk("seq1_c0_s1", 32'(s1), 32'd1);
      chk("seq1_c0_f1", 32'(f1), 32'd0);
      chk("seq1_c0_s4", 32'(s4), 32'd1);
      next_cycle();
      idle_in();
      pcsource = 2'd2;
      rs = 5'd6; use_rs = 1'b1; mrn = 5'd6; mwreg = 1'b1;
      @(negedge clk);
      chk("seq1_c1_s3", 32'(s3), 32'd1);
      chk("seq1_c1_f3", 32'(f3), 32'd0);
      chk("seq1_c1_a3", 32'(a3), 32'd2);
      chk("seq1_c1_s1", 32'(s1), 32'd0);
      chk("seq1_c1_f1", 32'(f1), 32'd1);
      chk("seq1_c1_s4", 32'(s4), 32'd1);
      next_cycle();
      @(negedge clk);
      chk("seq1_c2_s3", 32'(s3), 32'd1);
      chk("seq1_c2_b3", 32'(b3), 32'd1);
      chk("seq1_c2_s4", 32'(s4), 32'd1);
      next_cycle();
      @(negedge clk);
      chk("seq1_c3_s3", 32'(s3), 32'd0);
      chk("seq1_c3_b3", 32'(b3), 32'd0);
      chk("seq1_c3_f3", 32'(f3), 32'd1);
      chk("seq1_c3_cnt3", c3, 32'd3);
      chk("seq1_c3_s4", 32'(s4), 32'd1);
      chk("seq1_c3_f4", 32'(f4), 32'd0);
      next_cycle();
      @(negedge clk);
      chk("seq1_c4_s4", 32'(s4), 32'd0);
      chk("seq1_c4_f4", 32'(f4), 32'd1);
      chk("seq1_c4_cnt4_sat", 32'(c4), 32'd3);
      chk("seq1_c4_cnt3", c3, 32'd3);
      chk("seq1_c4_s3", 32'(s3), 32'd0);
      next_cycle();

      // Reset on the second cycle of a LOAD_LAT=4 stall
      do_reset();
      luh_in();
      @(negedge clk);
      chk("seq2_c0_s4", 32'(s4), 32'd1);
      next_cycle();
      clrn = 1'b1;
      pcsource = 2'd2;
      @(negedge clk);
      chk("seq2_c1_s4", 32'(s4), 32'd0);
      chk("seq2_c1_b4", 32'(b4), 32'd0);
      chk("seq2_c1_f4", 32'(f4), 32'd0);
      next_cycle();
      clrn = 1'b0;
      idle_in();
      pcsource = 2'd2;
      @(negedge clk);
      chk("seq2_c2_s4", 32'(s4), 32'd0);
      chk("seq2_c2_f4", 32'(f4), 32'd1);
      chk("seq2_c2_cnt4", 32'(c4), 32'd0);
      chk("seq2_c2_cnt3", c3, 32'd0);
      next_cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
